pkt_receiver: RTL and testbench
===============================

PKT_RECEIVER -- requirements
Module: pkt_receiver

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PID_DATA0, 4'b0011, DATA0 PID code.
- SYNC_PAT, 8'b1000_0000, SYNC byte; bit 0 is the first bit received.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, single clock; all logic on posedge.
- reset, in, 1, synchronous, active-high.
- bit_in, in, 1, decoded, unstuffed line bit.
- bit_valid, in, 1, bit_in is valid this cycle.
- eop, in, 1, end-of-packet strobe from the line stage.
- rec_start, out, 1, packet reception in progress.
- rec_DATA0, out, 1, one-cycle pulse: DATA0 packet ended.
- data_valid, out, 1, qualifies rec_DATA0: length and CRC correct.
- data_rec, out, 64, last DATA0 payload.
- rec_other, out, 1, one-cycle pulse: good non-DATA0 PID ended.
- pid_rec, out, 4, last accepted PID.
- pid_err, out, 1, one-cycle pulse: PID check failed.
REQ-003 The clock SHALL be one clock; reset SHALL be synchronous and active-high. No other clock or asynchronous input path exists.

Function
REQ-004 Bits SHALL be consumed only on cycles with bit_valid=1, LSB-first per field.
REQ-005 The FSM SHALL have states HUNT, PID, BODY and REPORT.
REQ-006 In HUNT, an 8-bit history of consumed bits SHALL be compared against SYNC_PAT; on a match the FSM SHALL go to PID and rec_start SHALL rise the next cycle.
REQ-007 eop SHALL be ignored in HUNT.
REQ-008 In PID, 8 bits SHALL be collected. If bits[7:4] != ~bits[3:0], pid_err SHALL pulse and the FSM SHALL return to HUNT. Otherwise pid_rec SHALL load bits[3:0] and the FSM SHALL go to BODY.
REQ-009 If eop arrives in PID, pid_err SHALL pulse and the FSM SHALL return to HUNT.
REQ-010 In BODY, each bit SHALL be shifted into a 64-bit payload shift register (first bit ends up at bit 0) and into a CRC16.
- CRC16 polynomial: x^16+x^15+x^2+1, initialised to 16'hFFFF at PID exit.
- A 7-bit saturating counter SHALL count BODY bits.
REQ-011 BODY SHALL exit to REPORT on eop. If bit_valid and eop are high in the same cycle, the bit SHALL be consumed first.
REQ-012 REPORT SHALL last exactly one cycle, then return to HUNT. rec_start SHALL be high in every cycle from the cycle after the SYNC match through REPORT inclusive.
REQ-013 In REPORT with pid_rec == PID_DATA0:
- rec_DATA0=1.
- data_valid=1 iff count==80 and the CRC residual == 16'h800D.
- data_rec SHALL load the payload register whenever count>=64, regardless of data_valid.
REQ-014 In REPORT with any other PID, rec_other=1 and data_rec SHALL be unchanged.
REQ-015 rec_DATA0, data_valid, rec_other and pid_err SHALL each be high for exactly one cycle per event.
REQ-016 data_rec and pid_rec SHALL hold their values between packets.
REQ-017 A SYNC_PAT appearing inside BODY SHALL be treated as data, not as resynchronisation.
REQ-018 If the count saturates at 127, data_valid SHALL be 0 at REPORT.

Reset
REQ-019 While reset=1, the FSM SHALL be in HUNT, and the history register, counter, CRC, data_rec and pid_rec SHALL be 0. All outputs SHALL be 0.
REQ-020 Reset asserted mid-packet SHALL abort the packet with no pulse on any output. The first consumed bit after reset deassertion SHALL be the first history bit.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Send SYNC, PID 8'hC3, payload 64'h0123_4567_89AB_CDEF, correct CRC (from the bench model), then eop -> rec_start spans the packet; one cycle rec_DATA0=1, data_valid=1; data_rec=64'h0123_4567_89AB_CDEF.
- Same packet with payload bit 17 flipped -> rec_DATA0=1, data_valid=0; data_rec equals the corrupted payload.
- Send SYNC, PID 8'hD2 (ACK), eop -> rec_other=1 for one cycle, pid_rec=4'h2; rec_DATA0 stays 0; data_rec unchanged.
- Send SYNC, PID 8'hC2 (bad complement) -> pid_err=1 for one cycle; FSM back in HUNT; no rec_DATA0.
- Good DATA0 truncated to 70 BODY bits, or extended to 81 -> data_valid=0. Random bit_valid gaps and bit_valid+eop in the same cycle produce results identical to the gap-free case.
- reset=1 at BODY bit 40, then a complete good packet -> no pulses during the aborted packet; the second packet reports data_valid=1.

Source files
------------

// File: rtl/pkt_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pkt_receiver                                                 |
// | Description : Serial packet receiver: SYNC hunt, PID check, 64-bit payload |
// |               capture with CRC16 residual check and end-of-packet report.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pkt_receiver #(
  parameter logic [3:0] PID_DATA0 = 4'b0011,
  parameter logic [7:0] SYNC_PAT  = 8'b1000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        eop,
  output logic        rec_start,
  output logic        rec_DATA0,
  output logic        data_valid,
  output logic [63:0] data_rec,
  output logic        rec_other,
  output logic [3:0]  pid_rec,
  output logic        pid_err
);

  localparam logic [1:0]  c_S_HUNT   = 2'd0;
  localparam logic [1:0]  c_S_PID    = 2'd1;
  localparam logic [1:0]  c_S_BODY   = 2'd2;
  localparam logic [1:0]  c_S_REPORT = 2'd3;
  localparam logic [15:0] c_CRC_POLY = 16'h8005;
  localparam logic [15:0] c_CRC_INIT = 16'hFFFF;
  localparam logic [15:0] c_CRC_RES  = 16'h800D;
  localparam logic [6:0]  c_CNT_MAX  = 7'd127;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [6:0]  r_hist;
  logic [6:0]  r_pid_sr;
  logic [6:0]  r_cnt;
  logic [15:0] r_crc;
  logic [63:0] r_payload;
  logic [63:0] r_data_rec;
  logic [3:0]  r_pid_rec;
  logic        r_pid_err;

  logic [7:0]  w_hist;
  logic [7:0]  w_pid;
  logic        w_sync_hit;
  logic        w_pid_last;
  logic        w_pid_ok;
  logic        w_crc_fb;
  logic [15:0] w_crc_next;
  logic        w_report;

  // 8-bit history window: the seven stored bits plus the bit arriving now
  assign w_hist     = {bit_in, r_hist};
  assign w_pid      = {bit_in, r_pid_sr};
  assign w_sync_hit = bit_valid && (w_hist == SYNC_PAT);
  assign w_pid_last = bit_valid && (r_cnt == 7'd7);
  assign w_pid_ok   = (w_pid[7:4] == ~w_pid[3:0]);
  assign w_crc_fb   = r_crc[15] ^ bit_in;
  assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? c_CRC_POLY : 16'h0000);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_S_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_HUNT:   if (w_sync_hit) w_state_next = c_S_PID;
      c_S_PID: begin
        if (eop) begin
          w_state_next = c_S_HUNT;
        end else if (w_pid_last) begin
          w_state_next = w_pid_ok ? c_S_BODY : c_S_HUNT;
        end
      end
      c_S_BODY:   if (eop) w_state_next = c_S_REPORT;
      default:    w_state_next = c_S_HUNT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hist     <= '0;
      r_pid_sr   <= '0;
      r_cnt      <= '0;
      r_crc      <= '0;
      r_payload  <= '0;
      r_data_rec <= '0;
      r_pid_rec  <= '0;
      r_pid_err  <= 1'b0;
    end else begin
      r_pid_err <= 1'b0;
      case (r_state)
        c_S_HUNT: begin
          r_cnt <= '0;
          if (bit_valid) r_hist <= w_sync_hit ? '0 : w_hist[7:1];
        end
        c_S_PID: begin
          if (eop) begin
            r_pid_err <= 1'b1;
          end else if (bit_valid) begin
            r_pid_sr <= w_pid[7:1];
            r_cnt    <= r_cnt + 7'd1;
            if (r_cnt == 7'd7) begin
              r_cnt <= '0;
              r_crc <= c_CRC_INIT;
              if (w_pid_ok) r_pid_rec <= w_pid[3:0];
              else          r_pid_err <= 1'b1;
            end
          end
        end
        c_S_BODY: begin
          if (bit_valid) begin
            // Payload keeps only the first 64 body bits; CRC sees every bit
            if (r_cnt < 7'd64) r_payload <= {bit_in, r_payload[63:1]};
            r_crc <= w_crc_next;
            if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 7'd1;
          end
        end
        default: begin
          if ((r_pid_rec == PID_DATA0) && (r_cnt >= 7'd64)) r_data_rec <= r_payload;
        end
      endcase
    end
  end

  assign w_report = (r_state == c_S_REPORT) && !reset;

  always_comb begin
    rec_start  = (r_state != c_S_HUNT) && !reset;
    rec_DATA0  = w_report && (r_pid_rec == PID_DATA0);
    rec_other  = w_report && (r_pid_rec != PID_DATA0);
    data_valid = rec_DATA0 && (r_cnt == 7'd80) && (r_crc == c_CRC_RES);
    pid_err    = r_pid_err && !reset;
    data_rec   = r_data_rec;
    pid_rec    = r_pid_rec;
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pkt_receiver                                              |
// | Description : Random + directed scoreboard bench for pkt_receiver.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pkt_receiver;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [7:0] SYNC_PAT  = 8'b1000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        eop = 1'b0;
  logic        rec_start, rec_DATA0, data_valid, rec_other, pid_err;
  logic [63:0] data_rec;
  logic [3:0]  pid_rec;

  pkt_receiver #(.PID_DATA0(PID_DATA0), .SYNC_PAT(SYNC_PAT)) dut (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .eop(eop),
    .rec_start(rec_start), .rec_DATA0(rec_DATA0), .data_valid(data_valid),
    .data_rec(data_rec), .rec_other(rec_other), .pid_rec(pid_rec), .pid_err(pid_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          kind;   // 0 DATA0 report, 1 other report, 2 PID error
    logic [3:0]  pid;
    logic        valid;
    logic [63:0] data;
  } ev_t;

  ev_t         exp_q[$];
  bit          pkt_bits[$];
  logic [63:0] model_data = '0;
  bit          gaps_on = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [63:0] d);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < 64; i++) c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h8005) : (c << 1);
    return c;
  endfunction

  // Reference: derive the expected report straight from the packet contents
  task automatic model_pkt();
    ev_t         e;
    logic [7:0]  p;
    logic [63:0] pay;
    logic [15:0] fld;
    int          n, cnt;
    e.valid = 1'b0;
    e.pid   = '0;
    if (pkt_bits.size() < 8) begin
      e.kind = 2; e.data = model_data; exp_q.push_back(e); return;
    end
    for (int i = 0; i < 8; i++) p[i] = pkt_bits[i];
    if (p[7:4] != ~p[3:0]) begin
      e.kind = 2; e.data = model_data; exp_q.push_back(e); return;
    end
    n   = pkt_bits.size() - 8;
    cnt = (n > 127) ? 127 : n;
    e.pid = p[3:0];
    if (p[3:0] == PID_DATA0) begin
      e.kind = 0;
      if (cnt >= 64) begin
        for (int i = 0; i < 64; i++) pay[i] = pkt_bits[8 + i];
        model_data = pay;
        if (cnt == 80) begin
          for (int k = 0; k < 16; k++) fld[15 - k] = pkt_bits[72 + k];
          e.valid = (fld == ~crc16(pay));
        end
      end
    end else begin
      e.kind = 1;
    end
    e.data = model_data;
    exp_q.push_back(e);
  endtask

  task automatic build(input logic [7:0] pid, input logic [63:0] data, input int nbody, input int flip);
    logic [79:0] full;
    logic [15:0] c;
    bit          b;
    c = ~crc16(data);
    full[63:0] = data;
    for (int k = 0; k < 16; k++) full[64 + k] = c[15 - k];
    pkt_bits.delete();
    for (int i = 0; i < 8; i++) pkt_bits.push_back(pid[i]);
    for (int i = 0; i < nbody; i++) begin
      b = (i < 80) ? full[i] : 1'($urandom);
      if (i == flip) b = ~b;
      pkt_bits.push_back(b);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic e);
    bit_valid = v; bit_in = b; eop = e;
    @(posedge clock); #1;
  endtask

  task automatic send_bit(input logic b);
    if (gaps_on) repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom), 1'b0);
    drive(1'b1, b, 1'b0);
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = SYNC_PAT;
    check("rec_start_idle", rec_start, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(s[i]);
    check("rec_start_after_sync", rec_start, 1'b1);
  endtask

  task automatic send_pkt(input bit merge);
    model_pkt();
    send_sync();
    for (int i = 0; i < pkt_bits.size(); i++) begin
      if (merge && (i == pkt_bits.size() - 1) && (pkt_bits.size() > 8)) begin
        if (gaps_on) repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom), 1'b0);
        drive(1'b1, pkt_bits[i], 1'b1);
      end else begin
        send_bit(pkt_bits[i]);
      end
    end
    if (!(merge && pkt_bits.size() > 8)) drive(1'b0, 1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    check("rec_start_back_to_hunt", rec_start, 1'b0);
  endtask

  task automatic check_reset_outputs();
    @(negedge clock);
    check("rst_rec_start", rec_start, 1'b0);
    check("rst_rec_DATA0", rec_DATA0, 1'b0);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_rec_other", rec_other, 1'b0);
    check("rst_pid_err", pid_err, 1'b0);
    check("rst_data_rec", data_rec, 64'h0);
    check("rst_pid_rec", pid_rec, 4'h0);
  endtask

  // Monitor: pops one expectation per reported event
  initial begin : monitor
    ev_t e;
    int  kind;
    forever begin
      @(negedge clock);
      if (!reset && (rec_DATA0 || rec_other || pid_err)) begin
        kind = rec_DATA0 ? 0 : (rec_other ? 1 : 2);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 64'(kind), 64'(e.kind));
          check("one_pulse", 64'($countones({rec_DATA0, rec_other, pid_err})), 64'd1);
          check("data_valid", data_valid, e.valid);
          if (e.kind != 2) begin
            check("rec_start_in_report", rec_start, 1'b1);
            check("pid_rec", pid_rec, e.pid);
          end
          @(negedge clock);
          check("pulse_width", {rec_DATA0, rec_other, pid_err, data_valid}, 4'h0);
          check("data_rec", data_rec, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [63:0] d;
    logic [7:0]  p;
    logic [3:0]  nib;
    int          sel, nb, fl;
    int          lens[8] = '{80, 80, 80, 70, 81, 40, 64, 79};
    reset = 1'b1;
    repeat (2) @(posedge clock);
    check_reset_outputs();
    @(posedge clock); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1);  // eop in HUNT must be ignored
    drive(1'b0, 1'b0, 1'b0);

    build(8'hC3, 64'h0123_4567_89AB_CDEF, 80, -1);  send_pkt(1'b0);
    build(8'hC3, 64'h0123_4567_89AB_CDEF, 80, 17);  send_pkt(1'b0);
    build(8'hD2, 64'h0, 0, -1);                     send_pkt(1'b0);
    build(8'hC2, 64'h0, 0, -1);                     send_pkt(1'b0);
    build(8'hC3, 64'h8080_8080_8080_8080, 80, -1);  send_pkt(1'b0);
    build(8'hC3, 64'h1111_2222_3333_4444, 70, -1);  send_pkt(1'b0);
    build(8'hC3, 64'h5555_6666_7777_8888, 81, -1);  send_pkt(1'b0);
    build(8'hC3, 64'h0F0F_F0F0_1234_ABCD, 130, -1); send_pkt(1'b0);
    gaps_on = 1'b1;
    build(8'hC3, 64'h0123_4567_89AB_CDEF, 80, -1);  send_pkt(1'b1);
    build(8'hC3, 64'hDEAD_BEEF_CAFE_F00D, 80, -1);  send_pkt(1'b0);
    gaps_on = 1'b0;

    // Reset in the middle of BODY: no event expected
    build(8'hC3, 64'hAAAA_5555_AAAA_5555, 80, -1);
    send_sync();
    for (int i = 0; i < 48; i++) send_bit(pkt_bits[i]);
    reset = 1'b1;
    model_data = '0;
    drive(1'b0, 1'b0, 1'b0);
    check_reset_outputs();
    @(posedge clock); #1;
    reset = 1'b0;
    build(8'hC3, 64'hAAAA_5555_AAAA_5555, 80, -1);  send_pkt(1'b0);

    for (int t = 0; t < 30; t++) begin
      gaps_on = 1'($urandom);
      d  = {$urandom, $urandom};
      sel = $urandom_range(0, 5);
      fl = -1;
      if (sel <= 2) begin
        p  = 8'hC3;
        nb = lens[$urandom_range(0, 7)];
        if ($urandom_range(0, 3) == 0) fl = $urandom_range(0, 79);
      end else if (sel <= 4) begin
        do nib = 4'($urandom); while (nib == PID_DATA0);
        p  = {~nib, nib};
        nb = $urandom_range(0, 20);
      end else begin
        do p = 8'($urandom); while (p[7:4] == ~p[3:0]);
        nb = 0;
      end
      build(p, d, nb, fl);
      send_pkt(1'($urandom));
    end

    repeat (5) drive(1'b0, 1'b0, 1'b0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
